// File: rtl/serial_word_collector_if.sv
// Serial-in / word-out bundle between a shift-register source, the collector and its consumer.
interface serial_word_collector_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             s_in;
    logic             shift_valid;
    logic             dir;
    logic             word_ready;
    logic             clr_flags;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             busy;
    logic             overrun;
    logic             dir_err;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output s_in, shift_valid, dir, word_ready, clr_flags,
        input  word, word_valid, busy, overrun, dir_err, word_cnt
    );

    modport slave (
        input  s_in, shift_valid, dir, word_ready, clr_flags,
        output word, word_valid, busy, overrun, dir_err, word_cnt
    );
endinterface

// File: rtl/serial_word_collector.sv
// Assembles WIDTH-bit words from a serial stream in LSB- or MSB-first order and
// presents them through a one-entry valid/ready buffer with overrun/direction flags.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | no partial word; next valid bit starts a word
//   COLLECT | partial word in progress, bit_k bits stored
module serial_word_collector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst_l,
    serial_word_collector_if.slave bus
);
    localparam int K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state;
    logic [K_W-1:0]   bit_k;
    logic [WIDTH-1:0] asm_reg;
    logic             dir_lat;

    logic [WIDTH-1:0] word_q;
    logic             word_valid_q;
    logic             busy_q;
    logic             overrun_q;
    logic             dir_err_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic             dir_mismatch;
    logic             restart;
    logic             cap_dir;
    logic [K_W-1:0]   cap_k;
    logic [K_W-1:0]   cap_pos;
    logic [WIDTH-1:0] asm_next;
    logic             complete;
    logic             xfer;
    logic             load;
    logic             drop;

    // A new word starts from a cleared assembly register, either from IDLE or
    // after a mid-word direction change discards the partial word.
    always_comb begin
        dir_mismatch = (state == COLLECT) && (bus.dir != dir_lat);
        restart      = (state == IDLE) || dir_mismatch;
        cap_dir      = restart ? bus.dir : dir_lat;
        cap_k        = restart ? '0 : bit_k;
        cap_pos      = cap_dir ? cap_k : (K_LAST - cap_k);
        asm_next     = restart ? '0 : asm_reg;
        asm_next[cap_pos] = bus.s_in;
        complete     = bus.shift_valid && (cap_k == K_LAST);
        xfer         = word_valid_q && bus.word_ready;
        load         = complete && (!word_valid_q || bus.word_ready);
        drop         = complete && word_valid_q && !bus.word_ready;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= IDLE;
            bit_k        <= '0;
            asm_reg      <= '0;
            dir_lat      <= 1'b1;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            dir_err_q    <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            if (bus.shift_valid) begin
                dir_lat <= cap_dir;
                if (complete) begin
                    state   <= IDLE;
                    bit_k   <= '0;
                    asm_reg <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    state   <= COLLECT;
                    bit_k   <= cap_k + K_W'(1);
                    asm_reg <= asm_next;
                    busy_q  <= 1'b1;
                end
            end

            if (load) begin
                word_q       <= asm_next;
                word_valid_q <= 1'b1;
            end else if (xfer) begin
                word_valid_q <= 1'b0;
            end

            if (xfer)
                word_cnt_q <= word_cnt_q + CNT_W'(1);

            // Set events take priority over a same-edge clear.
            overrun_q <= (overrun_q & ~bus.clr_flags) | drop;
            dir_err_q <= (dir_err_q & ~bus.clr_flags) | (bus.shift_valid & dir_mismatch);
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
    assign bus.dir_err    = dir_err_q;
    assign bus.word_cnt   = word_cnt_q;
endmodule
